// File: rtl/sys_cmd_pkg.sv
// Shared types, opcodes and frame/response length helpers for the UART command initiator.
package sys_cmd_pkg;

    localparam logic [7:0] RF_WR_CMD   = 8'hAA;
    localparam logic [7:0] RF_RD_CMD   = 8'hBB;
    localparam logic [7:0] ALU_OP_CMD  = 8'hCC;
    localparam logic [7:0] ALU_NOP_CMD = 8'hDD;

    localparam int unsigned IDX_W  = 2;
    localparam int unsigned LEN_W  = 3;
    localparam int unsigned RCNT_W = 2;
    localparam int unsigned TO_W   = 16;

    typedef enum logic [1:0] {
        CMD_RF_WR   = 2'd0,
        CMD_RF_RD   = 2'd1,
        CMD_ALU_OP  = 2'd2,
        CMD_ALU_NOP = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_DONE     = 2'd3
    } state_e;

    typedef struct packed {
        cmd_e       cmd;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] op_a;
        logic [7:0] op_b;
        logic [3:0] fun;
    } req_fields_t;

    // Number of bytes in the outgoing frame, opcode included.
    function automatic logic [LEN_W-1:0] frame_len(input cmd_e cmd);
        case (cmd)
            CMD_RF_WR:  return LEN_W'(3);
            CMD_RF_RD:  return LEN_W'(2);
            CMD_ALU_OP: return LEN_W'(4);
            default:    return LEN_W'(2);
        endcase
    endfunction

    // Number of response bytes the controller returns.
    function automatic logic [RCNT_W-1:0] rsp_len(input cmd_e cmd);
        case (cmd)
            CMD_RF_WR: return RCNT_W'(0);
            CMD_RF_RD: return RCNT_W'(1);
            default:   return RCNT_W'(2);
        endcase
    endfunction

endpackage

// File: rtl/sys_cmd_master_frame_mux.sv
// Selects the outgoing frame byte from the latched request fields and the byte index.
module sys_cmd_master_frame_mux
    import sys_cmd_pkg::*;
(
    input  req_fields_t      fields,
    input  logic [IDX_W-1:0] idx,
    output logic [7:0]       frame_byte_c,
    output logic [LEN_W-1:0] frame_len_c
);

    assign frame_len_c = frame_len(fields.cmd);

    always_comb begin
        frame_byte_c = 8'h00;
        case (fields.cmd)
            CMD_RF_WR: begin
                case (idx)
                    2'd0:    frame_byte_c = RF_WR_CMD;
                    2'd1:    frame_byte_c = {4'h0, fields.addr};
                    2'd2:    frame_byte_c = fields.wdata;
                    default: frame_byte_c = 8'h00;
                endcase
            end
            CMD_RF_RD: begin
                case (idx)
                    2'd0:    frame_byte_c = RF_RD_CMD;
                    2'd1:    frame_byte_c = {4'h0, fields.addr};
                    default: frame_byte_c = 8'h00;
                endcase
            end
            CMD_ALU_OP: begin
                case (idx)
                    2'd0:    frame_byte_c = ALU_OP_CMD;
                    2'd1:    frame_byte_c = fields.op_a;
                    2'd2:    frame_byte_c = fields.op_b;
                    default: frame_byte_c = {4'h0, fields.fun};
                endcase
            end
            default: begin
                case (idx)
                    2'd0:    frame_byte_c = ALU_NOP_CMD;
                    2'd1:    frame_byte_c = {4'h0, fields.fun};
                    default: frame_byte_c = 8'h00;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/sys_cmd_master.sv
// Host-side UART command initiator: serialises one request, collects the response.
// Optional response timeout enabled by defining SYS_CMD_TIMEOUT_EN.
module sys_cmd_master
    import sys_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_cmd,
    input  logic [3:0]  req_addr,
    input  logic [7:0]  req_wdata,
    input  logic [7:0]  req_op_a,
    input  logic [7:0]  req_op_b,
    input  logic [3:0]  req_fun,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_timeout,
    output logic        busy
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("sys_cmd_master: TIMEOUT_CYCLES must be at least 2");
    end

    state_e              state_q, state_nx;
    req_fields_t         fld_q, fld_nx;
    logic [IDX_W-1:0]    idx_q, idx_nx;
    logic [RCNT_W-1:0]   rcnt_q, rcnt_nx;
    logic [15:0]         rsp_nx;
    logic [7:0]          frame_byte_c;
    logic [LEN_W-1:0]    frame_len_c;
    logic                load_c;
    logic                last_c;

`ifdef SYS_CMD_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_nx;
    logic            tout_nx;
`endif

    // Mux is fed the next-cycle fields/index so tx_data can be registered.
    sys_cmd_master_frame_mux u_frame_mux (
        .fields       (fld_nx),
        .idx          (idx_nx),
        .frame_byte_c (frame_byte_c),
        .frame_len_c  (frame_len_c)
    );

    assign load_c = (state_q == ST_IDLE) && req_valid;
    assign last_c = (state_q == ST_SEND) &&
                    ({1'b0, idx_q} == (frame_len_c - LEN_W'(1)));

    // Request field latch and byte index.
    always_comb begin
        fld_nx = fld_q;
        idx_nx = idx_q;
        if (load_c) begin
            fld_nx = '{cmd:   cmd_e'(req_cmd),
                       addr:  req_addr,
                       wdata: req_wdata,
                       op_a:  req_op_a,
                       op_b:  req_op_b,
                       fun:   req_fun};
            idx_nx = '0;
        end else if ((state_q == ST_SEND) && tx_ready && !last_c) begin
            idx_nx = idx_q + IDX_W'(1);
        end
    end

    // Next-state and response assembly.
    always_comb begin
        state_nx = state_q;
        rcnt_nx  = rcnt_q;
        rsp_nx   = rsp_data;
`ifdef SYS_CMD_TIMEOUT_EN
        to_cnt_nx = '0;
        tout_nx   = rsp_timeout;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    rcnt_nx  = '0;
                    rsp_nx   = '0;
`ifdef SYS_CMD_TIMEOUT_EN
                    tout_nx  = 1'b0;
`endif
                    state_nx = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_ready && last_c) begin
                    state_nx = (fld_q.cmd == CMD_RF_WR) ? ST_DONE : ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
`ifdef SYS_CMD_TIMEOUT_EN
                to_cnt_nx = rx_valid ? '0 : to_cnt_q + TO_W'(1);
`endif
                if (rx_valid) begin
                    if (rcnt_q == '0) begin
                        rsp_nx[7:0] = rx_data;
                    end else begin
                        rsp_nx[15:8] = rx_data;
                    end
                    rcnt_nx = rcnt_q + RCNT_W'(1);
                    if (rcnt_nx == rsp_len(fld_q.cmd)) begin
                        state_nx = ST_DONE;
                    end
                end
`ifdef SYS_CMD_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    state_nx = ST_DONE;
                    tout_nx  = 1'b1;
                end
`endif
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            fld_q     <= '0;
            idx_q     <= '0;
            rcnt_q    <= '0;
            rsp_data  <= '0;
            tx_valid  <= 1'b0;
            tx_data   <= 8'h00;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            state_q   <= state_nx;
            fld_q     <= fld_nx;
            idx_q     <= idx_nx;
            rcnt_q    <= rcnt_nx;
            rsp_data  <= rsp_nx;
            tx_valid  <= (state_nx == ST_SEND);
            tx_data   <= (state_nx == ST_SEND) ? frame_byte_c : 8'h00;
            req_ready <= (state_nx == ST_IDLE);
            busy      <= (state_nx != ST_IDLE);
            rsp_valid <= (state_nx == ST_DONE);
        end
    end

`ifdef SYS_CMD_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q    <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            to_cnt_q    <= to_cnt_nx;
            rsp_timeout <= tout_nx;
        end
    end
`else
    assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_sys_cmd_master.sv
// Scoreboard bench for sys_cmd_master: directed requests, expected bytes/responses queued.
module tb_sys_cmd_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_cmd;
    logic [3:0]  req_addr;
    logic [7:0]  req_wdata;
    logic [7:0]  req_op_a;
    logic [7:0]  req_op_b;
    logic [3:0]  req_fun;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_timeout;
    logic        busy;

    typedef struct packed {
        logic        tout;
        logic [15:0] data;
    } rsp_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   n_rsp   = 0;
    int   rsp_cyc = 0;
    int   exp_n   = 0;
    logic [7:0] exp_tx[$];
    rsp_t       exp_rsp[$];

    sys_cmd_master #(.TIMEOUT_CYCLES(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_cmd     (req_cmd),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_op_a    (req_op_a),
        .req_op_b    (req_op_b),
        .req_fun     (req_fun),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_timeout (rsp_timeout),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: unexpected event or expired wait (cycle %0d)", name, cyc);
    endtask

    // Monitor: every presented tx byte must match the queue head; every rsp pops one entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_valid) begin
                if (exp_tx.size() == 0) begin
                    fail_now("tx_unexpected");
                end else begin
                    check("tx_byte", {24'h0, tx_data}, {24'h0, exp_tx[0]});
                    if (tx_ready) void'(exp_tx.pop_front());
                end
            end
            if (rsp_valid) begin
                n_rsp++;
                rsp_cyc = cyc;
                if (exp_rsp.size() == 0) begin
                    fail_now("rsp_unexpected");
                end else begin
                    rsp_t e;
                    e = exp_rsp.pop_front();
                    check("rsp_data", {16'h0, rsp_data}, {16'h0, e.data});
                    check("rsp_timeout", {31'h0, rsp_timeout}, {31'h0, e.tout});
                end
            end
        end
    end

    task automatic push_rsp(input logic [15:0] d, input logic t);
        exp_rsp.push_back('{tout: t, data: d});
        exp_n++;
    endtask

    task automatic do_req(input logic [1:0] c, input logic [3:0] a, input logic [7:0] wd,
                          input logic [7:0] oa, input logic [7:0] ob, input logic [3:0] f,
                          output int hs);
        int g = 0;
        while (!req_ready && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        if (!req_ready) fail_now("req_ready_wait");
        req_cmd   = c;
        req_addr  = a;
        req_wdata = wd;
        req_op_a  = oa;
        req_op_b  = ob;
        req_fun   = f;
        req_valid = 1'b1;
        hs = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("tx_valid_rise", {31'h0, tx_valid}, 32'h1);
    endtask

    // Runs until the frame is fully accepted; bp toggles tx_ready every cycle.
    task automatic send_wait(input bit bp);
        int g = 0;
        while (g < 100) begin
            @(posedge clk); #1;
            g++;
            if (!tx_valid) break;
            if (bp) tx_ready = ~tx_ready;
        end
        if (tx_valid) fail_now("send_wait");
        tx_ready = 1'b1;
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        int g = 0;
        while (n_rsp < target && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        if (n_rsp < target) fail_now("rsp_wait");
    endtask

    initial begin
        int hs;
        int m;
        rst = 1'b1; req_valid = 1'b0; req_cmd = '0; req_addr = '0; req_wdata = '0;
        req_op_a = '0; req_op_b = '0; req_fun = '0; tx_ready = 1'b1;
        rx_data = '0; rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tx_valid",    {31'h0, tx_valid},    32'h0);
        check("rst_tx_data",     {24'h0, tx_data},     32'h0);
        check("rst_rsp_valid",   {31'h0, rsp_valid},   32'h0);
        check("rst_rsp_data",    {16'h0, rsp_data},    32'h0);
        check("rst_rsp_timeout", {31'h0, rsp_timeout}, 32'h0);
        check("rst_busy",        {31'h0, busy},        32'h0);
        check("rst_req_ready",   {31'h0, req_ready},   32'h1);
        rst = 1'b0;

        // Write: AA,05,3C back-to-back, response 4 cycles after handshake.
        exp_tx.push_back(8'hAA); exp_tx.push_back(8'h05); exp_tx.push_back(8'h3C);
        push_rsp(16'h0000, 1'b0);
        do_req(2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, hs);
        send_wait(1'b0);
        wait_rsp(exp_n);
        check("wr_latency", 32'(rsp_cyc - hs), 32'd4);

        // Read under backpressure, then one response byte.
        exp_tx.push_back(8'hBB); exp_tx.push_back(8'h0A);
        push_rsp(16'h0077, 1'b0);
        tx_ready = 1'b0;
        do_req(2'd1, 4'hA, 8'h00, 8'h00, 8'h00, 4'h0, hs);
        send_wait(1'b1);
        m = cyc;
        send_rx(8'h77);
        wait_rsp(exp_n);
        check("rd_latency", 32'(rsp_cyc - m), 32'd1);

        // ALU with operands.
        exp_tx.push_back(8'hCC); exp_tx.push_back(8'h12);
        exp_tx.push_back(8'h34); exp_tx.push_back(8'h02);
        push_rsp(16'h0046, 1'b0);
        do_req(2'd2, 4'h0, 8'h00, 8'h12, 8'h34, 4'h2, hs);
        send_wait(1'b0);
        send_rx(8'h46);
        send_rx(8'h00);
        wait_rsp(exp_n);

        // No-operand ALU with stray rx during SEND, including the last-accept cycle.
        exp_tx.push_back(8'hDD); exp_tx.push_back(8'h09);
        push_rsp(16'h0AF0, 1'b0);
        do_req(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h9, hs);
        rx_data = 8'h55; rx_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        check("nop_send_done", {31'h0, tx_valid}, 32'h0);
        send_rx(8'hF0);
        send_rx(8'h0A);
        wait_rsp(exp_n);
        send_rx(8'hEE);
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_extra_rx", {31'h0, busy}, 32'h0);

`ifdef SYS_CMD_TIMEOUT_EN
        exp_tx.push_back(8'hBB); exp_tx.push_back(8'h03);
        push_rsp(16'h0000, 1'b1);
        do_req(2'd1, 4'h3, 8'h00, 8'h00, 8'h00, 4'h0, hs);
        send_wait(1'b0);
        m = cyc;
        wait_rsp(exp_n);
        check("to_latency", 32'(rsp_cyc - m), 32'd8);
`else
        exp_tx.push_back(8'hBB); exp_tx.push_back(8'h03);
        do_req(2'd1, 4'h3, 8'h00, 8'h00, 8'h00, 4'h0, hs);
        send_wait(1'b0);
        repeat (1000) @(posedge clk);
        #1;
        check("no_timeout_busy", {31'h0, busy}, 32'h1);
        check("no_timeout_rsp_count", 32'(n_rsp), 32'(exp_n));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
`endif

        // Reset after two bytes of an ALU frame.
        exp_tx.push_back(8'hCC); exp_tx.push_back(8'h12);
        exp_tx.push_back(8'h34); exp_tx.push_back(8'h01);
        do_req(2'd2, 4'h0, 8'h00, 8'h12, 8'h34, 4'h1, hs);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_tx.delete();
        check("mid_rst_tx_valid",  {31'h0, tx_valid},  32'h0);
        check("mid_rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("mid_rst_busy",      {31'h0, busy},      32'h0);

        // Write after reset completes normally.
        exp_tx.push_back(8'hAA); exp_tx.push_back(8'h03); exp_tx.push_back(8'hC5);
        push_rsp(16'h0000, 1'b0);
        do_req(2'd0, 4'h3, 8'hC5, 8'h00, 8'h00, 4'h0, hs);
        send_wait(1'b0);
        wait_rsp(exp_n);
        check("wr2_latency", 32'(rsp_cyc - hs), 32'd4);

        repeat (3) @(posedge clk);
        #1;
        check("tx_queue_drained",  32'(exp_tx.size()),  32'd0);
        check("rsp_queue_drained", 32'(exp_rsp.size()), 32'd0);
        check("rsp_count",         32'(n_rsp),          32'(exp_n));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
